regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor to the single-read-port integer register file.
- Provides NUM_RD combinational read ports and one synchronous write port, with a hardwired-zero entry 0 selectable by parameter.
- Has a reset-driven clear sequencer that zeroes the array one entry per cycle, so the array can stay in plain flops/LUT-RAM without a parallel reset.
- Sits between the decode stage (read addresses) and the writeback stage (write port) of the core.

Parameters:
- ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH entries.
- DATA_WIDTH, 32, bits per entry.
- NUM_RD, 2, number of read ports (1..4).
- R0_ZERO, 1, 1: entry 0 reads as 0 and writes to it are dropped; 0: entry 0 is an ordinary register.
- CLR_VAL, 0, DATA_WIDTH-bit value written to every entry by the clear sequencer.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- rst, in, 1, synchronous active-high reset; starts the clear sequence.
- wen, in, 1, write enable.
- waddr, in, ADDR_WIDTH, write address.
- wdata, in, DATA_WIDTH, write data.
- raddr, in, NUM_RD*ADDR_WIDTH, packed read addresses; port i is raddr[i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata, out, NUM_RD*DATA_WIDTH, packed read data; port i is rdata[i*DATA_WIDTH +: DATA_WIDTH].
- busy, out, 1, high while the clear sequence runs; the writeback stage must stall.

Behaviour:
- The one clock is clk; reset is rst, synchronous and active-high.
- State machine, two states:
  - CLEAR:
    - On any edge with rst=1: state <= CLEAR, cnt <= 0, no array write.
    - On an edge with rst=0: rf[cnt] <= CLR_VAL, cnt <= cnt+1.
    - When cnt == DEPTH-1 the write completes and state <= READY.
  - READY: normal operation; stays READY until rst.
- Reset values: state=CLEAR, cnt=0, busy=1, rdata all zero.
- busy = (state == CLEAR), registered-state decode with no extra latency.
  - After rst falls, busy stays high for exactly DEPTH cycles; the first READY cycle is DEPTH cycles after rst deassertion.
- Reset mid-clear: cnt returns to 0 and the full DEPTH-cycle sequence restarts.
- Write (READY only):
  - If wen=1 and not (R0_ZERO && waddr==0), rf[waddr] <= wdata at the edge.
  - While busy, wen is ignored entirely; the sequencer is the only writer.
- Read:
  - rdata_i is combinational from raddr_i, with zero cycles of latency.
  - rdata_i = 0 if busy.
  - Else rdata_i = 0 if R0_ZERO && raddr_i==0.
  - Else rdata_i = rf[raddr_i].
- Read and write to the same address in one cycle:
  - Without bypass, the read returns the old value; the new value is visible the next cycle.
- Multiple read ports may use the same address and all return the same data.
- No X may propagate to rdata after the clear completes.
- Arithmetic: cnt is ADDR_WIDTH bits; the terminal test is cnt == DEPTH-1, with no wrap-around compare.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If READY, wen=1, waddr==raddr_i, and the write is not dropped by R0_ZERO, then rdata_i = wdata in the same cycle.
  - The R0_ZERO and busy rules still take precedence.
- Undefined: no forwarding; same-cycle reads return the old value.

Decomposition:
- Package regfile_pkg:
  - State enum {CLEAR, READY}.
  - Default parameter constants.
  - Function rd_slice(i) for packed-port indexing.
- Sub-module regfile_clear_seq:
  - Owns state and cnt.
  - Outputs busy, clr_we, clr_addr.
  - The top muxes the sequencer write against the user write port.
- Read ports are a generate loop in the top.

Test Plan:
- Clear sequence: assert rst 3 cycles, release. Required: busy=1 for exactly 32 cycles, then 0; all 32 entries read CLR_VAL=0 on both ports.
- Basic write and read: write x5=0xDEADBEEF, then raddr0=5, raddr1=5 next cycle. Required: both rdata = 0xDEADBEEF.
- x0 handling: write x0=0x12345678 with R0_ZERO=1. Required: read x0 = 0. With R0_ZERO=0: read x0 = 0x12345678.
- Same-cycle read/write of x7:
  - Setup: old value 0x1, write 0x2.
  - Without REGFILE_BYPASS_EN: rdata = 0x1 that cycle, 0x2 next cycle.
  - With REGFILE_BYPASS_EN: rdata = 0x2 in the same cycle.
- Reset mid-clear and write during busy:
  - Stimulus: rst pulse at clear cycle 10; wen=1, waddr=3, wdata=0xAA while busy.
  - Required: busy stays high 32 cycles after the second rst falls; rdata=0 while busy; x3 reads 0 afterwards.
- Parameter sweep: ADDR_WIDTH=4, DATA_WIDTH=64, NUM_RD=4, random writes against a reference model. Required: all ports match the model; busy lasts 16 cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types, default parameters and packed-port indexing helper for the register file.
package regfile_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   localparam int DEF_ADDR_WIDTH = 5;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_NUM_RD     = 2;
   localparam int DEF_R0_ZERO    = 1;

   // Base bit offset of port i in a packed bus of width-w lanes.
   function automatic int rd_slice(input int i, input int w);
      return i * w;
   endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Reset-driven clear sequencer: walks every entry once after rst falls, then reports READY.
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  o_busy,
   output logic                  o_clr_we,
   output logic [ADDR_WIDTH-1:0] o_clr_addr
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= CLEAR;
         r_cnt   <= '0;
      end else if (r_state == CLEAR) begin
         r_cnt <= r_cnt + ADDR_WIDTH'(1);
         if (r_cnt == LAST_ADDR) begin
            r_state <= READY;
         end
      end
   end

   // The edge that samples rst=1 must not write, so the strobe is gated by rst itself.
   assign o_busy     = (r_state == CLEAR);
   assign o_clr_we   = (r_state == CLEAR) && !rst;
   assign o_clr_addr = r_cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with one write port, optional hardwired-zero entry 0 and
// a sequential clear after reset. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int                  ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int                  DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int                  NUM_RD     = DEF_NUM_RD,
   parameter int                  R0_ZERO    = DEF_R0_ZERO,
   parameter logic [DATA_WIDTH-1:0] CLR_VAL  = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wen,
   input  logic [ADDR_WIDTH-1:0]        waddr,
   input  logic [DATA_WIDTH-1:0]        wdata,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
   output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
   output logic                         busy
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_rf [DEPTH];

   logic                  w_busy;
   logic                  w_clr_we;
   logic [ADDR_WIDTH-1:0] w_clr_addr;
   logic                  w_user_we;

   regfile_clear_seq #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_clear_seq (
      .clk        (clk),
      .rst        (rst),
      .o_busy     (w_busy),
      .o_clr_we   (w_clr_we),
      .o_clr_addr (w_clr_addr)
   );

   // User writes only land once the sequencer is done; writes to a hardwired x0 vanish.
   assign w_user_we = !w_busy && wen && !((R0_ZERO != 0) && (waddr == '0));

   always_ff @(posedge clk) begin
      if (w_clr_we) begin
         r_rf[w_clr_addr] <= CLR_VAL;
      end else if (w_user_we) begin
         r_rf[waddr] <= wdata;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [ADDR_WIDTH-1:0] w_ra;
         logic [DATA_WIDTH-1:0] w_rd;

         assign w_ra = raddr[rd_slice(gi, ADDR_WIDTH) +: ADDR_WIDTH];

         // Later assignments win: busy and x0 zeroing override any forwarded data.
         always_comb begin
            w_rd = r_rf[w_ra];
`ifdef REGFILE_BYPASS_EN
            if (w_user_we && (waddr == w_ra)) begin
               w_rd = wdata;
            end
`endif
            if (w_busy || ((R0_ZERO != 0) && (w_ra == '0))) begin
               w_rd = '0;
            end
         end

         assign rdata[rd_slice(gi, DATA_WIDTH) +: DATA_WIDTH] = w_rd;
      end
   endgenerate

   assign busy = w_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: default-parameter instance plus a 4-port/64-bit/16-entry instance with
// R0_ZERO=0, both compared against array models of the register file.
module tb_regfile_mp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: default parameters (32 x 32, 2 read ports, x0 hardwired).
   logic         rst_a   = 1'b1;
   logic         wen_a   = 1'b0;
   logic [4:0]   waddr_a = '0;
   logic [31:0]  wdata_a = '0;
   logic [9:0]   raddr_a = '0;
   logic [63:0]  rdata_a;
   logic         busy_a;

   // Instance B: 16 x 64, 4 read ports, x0 ordinary.
   logic         rst_b   = 1'b1;
   logic         wen_b   = 1'b0;
   logic [3:0]   waddr_b = '0;
   logic [63:0]  wdata_b = '0;
   logic [15:0]  raddr_b = '0;
   logic [255:0] rdata_b;
   logic         busy_b;

   regfile_mp u_dut_a (
      .clk   (clk),
      .rst   (rst_a),
      .wen   (wen_a),
      .waddr (waddr_a),
      .wdata (wdata_a),
      .raddr (raddr_a),
      .rdata (rdata_a),
      .busy  (busy_a)
   );

   regfile_mp #(
      .ADDR_WIDTH (4),
      .DATA_WIDTH (64),
      .NUM_RD     (4),
      .R0_ZERO    (0),
      .CLR_VAL    (64'h0)
   ) u_dut_b (
      .clk   (clk),
      .rst   (rst_b),
      .wen   (wen_b),
      .waddr (waddr_b),
      .wdata (wdata_b),
      .raddr (raddr_b),
      .rdata (rdata_b),
      .busy  (busy_b)
   );

   // Reference state: register contents plus number of clear cycles still to run.
   logic [31:0] model_a [32];
   logic [63:0] model_b [16];
   int          left_a = 32;
   int          left_b = 16;
   int          tests  = 0;
   int          fails  = 0;
   int          busy_cnt;

   function automatic logic [31:0] exp_a(input logic [4:0] ra);
      if (left_a > 0) return 32'h0;
      if (ra == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
      if (wen_a && waddr_a == ra) return wdata_a;
`endif
      return model_a[ra];
   endfunction

   function automatic logic [63:0] exp_b(input logic [3:0] ra);
      if (left_b > 0) return 64'h0;
`ifdef REGFILE_BYPASS_EN
      if (wen_b && waddr_b == ra) return wdata_b;
`endif
      return model_b[ra];
   endfunction

   // Apply the effect of the coming clock edge to both models, then advance past it.
   task automatic tick();
      if (rst_a) left_a = 32;
      else if (left_a > 0) begin
         left_a--;
         if (left_a == 0) foreach (model_a[k]) model_a[k] = 32'h0;
      end else if (wen_a && waddr_a != 5'd0) model_a[waddr_a] = wdata_a;

      if (rst_b) left_b = 16;
      else if (left_b > 0) begin
         left_b--;
         if (left_b == 0) foreach (model_b[k]) model_b[k] = 64'h0;
      end else if (wen_b) model_b[waddr_b] = wdata_b;

      @(posedge clk);
      #1;
   endtask

   task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_a(input string tag);
      #1;
      $display("[TB] A %-8s rst=%b wen=%b wa=%0d wd=%h ra=%h busy=%b rd=%h",
               tag, rst_a, wen_a, waddr_a, wdata_a, raddr_a, busy_a, rdata_a);
      cmp({tag, "_busy"}, 64'(busy_a), 64'(left_a > 0));
      for (int i = 0; i < 2; i++)
         cmp($sformatf("%s_rd%0d", tag, i), 64'(rdata_a[i*32 +: 32]), 64'(exp_a(raddr_a[i*5 +: 5])));
   endtask

   task automatic check_b(input string tag);
      #1;
      $display("[TB] B %-8s rst=%b wen=%b wa=%0d wd=%h ra=%h busy=%b rd=%h",
               tag, rst_b, wen_b, waddr_b, wdata_b, raddr_b, busy_b, rdata_b);
      cmp({tag, "_busy"}, 64'(busy_b), 64'(left_b > 0));
      for (int i = 0; i < 4; i++)
         cmp($sformatf("%s_rd%0d", tag, i), rdata_b[i*64 +: 64], exp_b(raddr_b[i*4 +: 4]));
   endtask

   initial begin
      foreach (model_a[k]) model_a[k] = 32'h0;
      foreach (model_b[k]) model_b[k] = 64'h0;

      // Reset held three cycles, then the full clear sequence.
      rst_a = 1'b1;
      repeat (3) tick();
      check_a("reset");
      rst_a    = 1'b0;
      busy_cnt = 0;
      for (int c = 0; c < 36; c++) begin
         raddr_a = 10'($urandom);
         check_a("clear");
         if (busy_a) busy_cnt++;
         tick();
      end
      cmp("busy_len_a", 64'(busy_cnt), 64'd32);

      for (int e = 0; e < 32; e++) begin
         raddr_a = {5'(31 - e), 5'(e)};
         check_a("scan");
         tick();
      end

      // Basic write then dual-port read of x5.
      wen_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'hDEADBEEF; raddr_a = {5'd2, 5'd1};
      check_a("wr_x5");
      tick();
      wen_a = 1'b0; raddr_a = {5'd5, 5'd5};
      check_a("rd_x5");
      cmp("x5_p1", 64'(rdata_a[63:32]), 64'hDEADBEEF);
      tick();

      // Writes to x0 are dropped.
      wen_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'h12345678;
      tick();
      wen_a = 1'b0; raddr_a = {5'd0, 5'd0};
      check_a("rd_x0");
      tick();

      // Same-cycle read/write of x7.
      wen_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'h1;
      tick();
      wdata_a = 32'h2; raddr_a = {5'd7, 5'd7};
      check_a("rw_x7");
`ifdef REGFILE_BYPASS_EN
      cmp("x7_same", 64'(rdata_a[31:0]), 64'h2);
`else
      cmp("x7_same", 64'(rdata_a[31:0]), 64'h1);
`endif
      tick();
      wen_a = 1'b0;
      check_a("rd_x7");
      cmp("x7_next", 64'(rdata_a[31:0]), 64'h2);
      tick();

      // Reset pulse at clear cycle 10 with writes attempted while busy.
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0; wen_a = 1'b1; waddr_a = 5'd3; wdata_a = 32'hAA; raddr_a = {5'd3, 5'd3};
      for (int c = 0; c < 10; c++) begin
         check_a("clr1");
         tick();
      end
      rst_a = 1'b1;
      tick();
      rst_a    = 1'b0;
      busy_cnt = 0;
      for (int c = 0; c < 34; c++) begin
         wen_a = (left_a > 0);
         check_a("clr2");
         if (busy_a) busy_cnt++;
         tick();
      end
      cmp("busy_len_a2", 64'(busy_cnt), 64'd32);
      wen_a = 1'b0; raddr_a = {5'd3, 5'd3};
      check_a("rd_x3");
      cmp("x3_after", 64'(rdata_a[31:0]), 64'h0);
      tick();

      // Random traffic, frequently aiming a read port at the write address.
      for (int c = 0; c < 120; c++) begin
         wen_a   = 1'($urandom_range(0, 1));
         waddr_a = 5'($urandom);
         wdata_a = $urandom;
         raddr_a = 10'($urandom);
         if ($urandom_range(0, 2) == 0) raddr_a[4:0] = waddr_a;
         check_a("rand");
         tick();
      end

      // Instance B: 16-entry clear, x0 as ordinary register, random sweep.
      rst_b = 1'b0;
      busy_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         raddr_b = 16'($urandom);
         check_b("clear");
         if (busy_b) busy_cnt++;
         tick();
      end
      cmp("busy_len_b", 64'(busy_cnt), 64'd16);

      wen_b = 1'b1; waddr_b = 4'd0; wdata_b = 64'h12345678;
      tick();
      wen_b = 1'b0; raddr_b = 16'h0;
      check_b("rd_x0");
      cmp("x0_b", rdata_b[63:0], 64'h12345678);
      tick();

      for (int c = 0; c < 150; c++) begin
         wen_b   = 1'($urandom_range(0, 1));
         waddr_b = 4'($urandom);
         wdata_b = {$urandom, $urandom};
         raddr_b = 16'($urandom);
         if ($urandom_range(0, 2) == 0) raddr_b[7:4] = waddr_b;
         check_b("rand");
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
